// File: rtl/zeroriscy_defines.sv
// zeroriscy_defines
//   Shared constants for the exception controller: FSM state encodings,
//   synchronous exception cause codes and PC mux selects.
package zeroriscy_defines;

    // Exception controller FSM states (legacy 2-bit encoding)
    localparam logic [1:0] EXC_ST_IDLE  = 2'd0;
    localparam logic [1:0] EXC_ST_FLUSH = 2'd1;
    localparam logic [1:0] EXC_ST_TRAP  = 2'd2;
    localparam logic [1:0] EXC_ST_MRET  = 2'd3;

    // Synchronous exception causes (bit5 = 0)
    localparam logic [5:0] EXC_CAUSE_ILLEGAL = 6'h02;
    localparam logic [5:0] EXC_CAUSE_EBRK    = 6'h03;
    localparam logic [5:0] EXC_CAUSE_ECALL   = 6'h0B;

    // PC mux selects; 0 means "no redirect" so both codes are non-zero
    localparam logic [1:0] PC_EXC  = 2'd1;
    localparam logic [1:0] PC_MRET = 2'd2;

endpackage

// File: rtl/zeroriscy_exc_controller.sv
// zeroriscy_exc_controller
//   Arbitrates synchronous exceptions, mret and interrupts, flushes the
//   pipeline while memory ops drain, then issues one trap (or mret) cycle
//   carrying the PC redirect and CSR save/restore strobes.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   irq_i, irq_id_i         level interrupt request and its id
//   irq_ack_o, irq_id_o     one-cycle ack pulse with the acked id
//   m_irq_enable_i          global MIE from the CSR block
//   instr_valid_i           ID stage holds a valid instruction
//   illegal/ecall/ebrk/mret_insn_i  decoded instruction flags from ID
//   lsu_busy_i              outstanding memory/multicycle op
//   halt_id_o               stall ID while flushing / trapping
//   pc_set_o, pc_mux_o      PC redirect strobe and source (PC_EXC/PC_MRET)
//   exc_vec_o               vector index of the trap
//   csr_save_cause_o, csr_save_if_o, csr_save_id_o, csr_restore_mret_o,
//   csr_cause_o             CSR block strobes and cause {irq, code[4:0]}
//   debug_state_o           current FSM state
//
// Handshake: irq_i is a level request; the controller samples it only in
// IDLE and acknowledges with a single-cycle irq_ack_o in the trap cycle.
// The source must drop or re-present irq_i itself; an unacked request is
// re-sampled every IDLE cycle.
module zeroriscy_exc_controller
    import zeroriscy_defines::*;
#(
    parameter logic [4:0] EXC_VEC_DEFAULT = 5'h1F
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       irq_i,
    input  logic [4:0] irq_id_i,
    output logic       irq_ack_o,
    output logic [4:0] irq_id_o,
    input  logic       m_irq_enable_i,
    input  logic       instr_valid_i,
    input  logic       illegal_insn_i,
    input  logic       ecall_insn_i,
    input  logic       ebrk_insn_i,
    input  logic       mret_insn_i,
    input  logic       lsu_busy_i,
    output logic       halt_id_o,
    output logic       pc_set_o,
    output logic [1:0] pc_mux_o,
    output logic [4:0] exc_vec_o,
    output logic       csr_save_cause_o,
    output logic       csr_save_if_o,
    output logic       csr_save_id_o,
    output logic       csr_restore_mret_o,
    output logic [5:0] csr_cause_o,
    output logic [1:0] debug_state_o
);

    logic [1:0] state_q,   state_d;
    logic       irq_req_q, irq_req_d;
    logic [4:0] irq_id_q,  irq_id_d;
    logic [5:0] cause_q,   cause_d;
    logic       save_id_q, save_id_d;   // 1: save ID pc, 0: save IF pc

    logic       exc_take;
    logic [5:0] exc_cause;

    // Synchronous exception priority: illegal > ebrk > ecall
    always_comb begin
        exc_take  = instr_valid_i & (illegal_insn_i | ebrk_insn_i | ecall_insn_i);
        exc_cause = EXC_CAUSE_ECALL;
        if (illegal_insn_i) begin
            exc_cause = EXC_CAUSE_ILLEGAL;
        end else if (ebrk_insn_i) begin
            exc_cause = EXC_CAUSE_EBRK;
        end
    end

    always_comb begin
        state_d   = state_q;
        irq_req_d = irq_req_q;
        irq_id_d  = irq_id_q;
        cause_d   = cause_q;
        save_id_d = save_id_q;
        case (state_q)
            EXC_ST_IDLE: begin
                irq_req_d = irq_i & m_irq_enable_i;
                irq_id_d  = irq_id_i;
                if (exc_take) begin
                    cause_d   = exc_cause;
                    save_id_d = 1'b1;
                    state_d   = EXC_ST_FLUSH;
                end else if (instr_valid_i && mret_insn_i) begin
                    state_d   = EXC_ST_MRET;
                end else if (irq_req_q && m_irq_enable_i) begin
                    // Once here the interrupt is committed: MIE dropping
                    // during FLUSH does not cancel it.
                    cause_d   = {1'b1, irq_id_q};
                    save_id_d = instr_valid_i;
                    state_d   = EXC_ST_FLUSH;
                end
            end
            EXC_ST_FLUSH: begin
                if (!lsu_busy_i) begin
                    state_d = EXC_ST_TRAP;
                end
            end
            EXC_ST_TRAP: begin
                if (cause_q[5]) begin
                    irq_req_d = 1'b0;
                end
                state_d = EXC_ST_IDLE;
            end
            default: begin
                state_d = EXC_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= EXC_ST_IDLE;
            irq_req_q <= 1'b0;
            irq_id_q  <= 5'd0;
            cause_q   <= 6'd0;
            save_id_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            irq_req_q <= irq_req_d;
            irq_id_q  <= irq_id_d;
            cause_q   <= cause_d;
            save_id_q <= save_id_d;
        end
    end

    // Outputs decode from state only, so reset clears them immediately.
    always_comb begin
        halt_id_o          = 1'b0;
        pc_set_o           = 1'b0;
        pc_mux_o           = 2'd0;
        exc_vec_o          = 5'd0;
        irq_ack_o          = 1'b0;
        irq_id_o           = 5'd0;
        csr_save_cause_o   = 1'b0;
        csr_save_if_o      = 1'b0;
        csr_save_id_o      = 1'b0;
        csr_restore_mret_o = 1'b0;
        csr_cause_o        = 6'd0;
        case (state_q)
            EXC_ST_FLUSH: begin
                halt_id_o = 1'b1;
            end
            EXC_ST_TRAP: begin
                halt_id_o        = 1'b1;
                pc_set_o         = 1'b1;
                pc_mux_o         = PC_EXC;
                csr_save_cause_o = 1'b1;
                csr_cause_o      = cause_q;
                csr_save_id_o    = save_id_q;
                csr_save_if_o    = ~save_id_q;
                exc_vec_o        = cause_q[5] ? cause_q[4:0] : EXC_VEC_DEFAULT;
                irq_ack_o        = cause_q[5];
                irq_id_o         = cause_q[5] ? cause_q[4:0] : 5'd0;
            end
            EXC_ST_MRET: begin
                halt_id_o          = 1'b1;
                pc_set_o           = 1'b1;
                pc_mux_o           = PC_MRET;
                csr_restore_mret_o = 1'b1;
            end
            default: begin
                halt_id_o = 1'b0;
            end
        endcase
    end

    assign debug_state_o = state_q;

endmodule

// File: tb/tb_zeroriscy_exc_controller.sv
// tb_zeroriscy_exc_controller
//   Directed bench for the exception controller: reset, exception/ecall
//   flush latency, interrupt trap and ack, priority, mret, MIE gating and
//   reset during flush.
module tb_zeroriscy_exc_controller;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FLUSH = 2'd1;
    localparam logic [1:0] S_TRAP  = 2'd2;
    localparam logic [1:0] S_MRET  = 2'd3;
    localparam int P_EXC  = 1;
    localparam int P_MRET = 2;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst_n;
    always #5 clk = ~clk;

    logic       irq_i, m_irq_enable_i, instr_valid_i;
    logic [4:0] irq_id_i;
    logic       illegal_insn_i, ecall_insn_i, ebrk_insn_i, mret_insn_i, lsu_busy_i;
    logic       irq_ack_o, halt_id_o, pc_set_o;
    logic [4:0] irq_id_o, exc_vec_o;
    logic [1:0] pc_mux_o, debug_state_o;
    logic       csr_save_cause_o, csr_save_if_o, csr_save_id_o, csr_restore_mret_o;
    logic [5:0] csr_cause_o;

    int n_tests = 0;
    int n_fail  = 0;

    zeroriscy_exc_controller #(.EXC_VEC_DEFAULT(5'h1F)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .irq_i              (irq_i),
        .irq_id_i           (irq_id_i),
        .irq_ack_o          (irq_ack_o),
        .irq_id_o           (irq_id_o),
        .m_irq_enable_i     (m_irq_enable_i),
        .instr_valid_i      (instr_valid_i),
        .illegal_insn_i     (illegal_insn_i),
        .ecall_insn_i       (ecall_insn_i),
        .ebrk_insn_i        (ebrk_insn_i),
        .mret_insn_i        (mret_insn_i),
        .lsu_busy_i         (lsu_busy_i),
        .halt_id_o          (halt_id_o),
        .pc_set_o           (pc_set_o),
        .pc_mux_o           (pc_mux_o),
        .exc_vec_o          (exc_vec_o),
        .csr_save_cause_o   (csr_save_cause_o),
        .csr_save_if_o      (csr_save_if_o),
        .csr_save_id_o      (csr_save_id_o),
        .csr_restore_mret_o (csr_restore_mret_o),
        .csr_cause_o        (csr_cause_o),
        .debug_state_o      (debug_state_o)
    );

    // ---------------- driver tasks ----------------
    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_instr();
        instr_valid_i  = 1'b0;
        illegal_insn_i = 1'b0;
        ecall_insn_i   = 1'b0;
        ebrk_insn_i    = 1'b0;
        mret_insn_i    = 1'b0;
    endtask

    // ---------------- checker ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full trap-cycle check: cause, save selection, vector and ack
    task automatic chk_trap(input string tag, input logic [5:0] cause, input logic save_id,
                            input logic [4:0] vec, input logic ack, input logic [4:0] ack_id);
        chk({tag, ".state"},   32'(debug_state_o),    32'(S_TRAP));
        chk({tag, ".save"},    32'(csr_save_cause_o), 1);
        chk({tag, ".cause"},   32'(csr_cause_o),      32'(cause));
        chk({tag, ".save_id"}, 32'(csr_save_id_o),    32'(save_id));
        chk({tag, ".save_if"}, 32'(csr_save_if_o),    32'(!save_id));
        chk({tag, ".pc_set"},  32'(pc_set_o),         1);
        chk({tag, ".pc_mux"},  32'(pc_mux_o),         P_EXC);
        chk({tag, ".halt"},    32'(halt_id_o),        1);
        chk({tag, ".vec"},     32'(exc_vec_o),        32'(vec));
        chk({tag, ".ack"},     32'(irq_ack_o),        32'(ack));
        chk({tag, ".ack_id"},  32'(irq_id_o),         32'(ack_id));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".state"},  32'(debug_state_o),    32'(S_IDLE));
        chk({tag, ".halt"},   32'(halt_id_o),        0);
        chk({tag, ".pc_set"}, 32'(pc_set_o),         0);
        chk({tag, ".save"},   32'(csr_save_cause_o), 0);
        chk({tag, ".ack"},    32'(irq_ack_o),        0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin : stim
        logic seen_ack;
        logic seen_save;

        rst_n          = 1'b0;
        irq_i          = 1'b0;
        irq_id_i       = 5'd0;
        m_irq_enable_i = 1'b0;
        lsu_busy_i     = 1'b0;
        clear_instr();
        tick();
        tick();
        chk_idle("reset");
        chk("reset.cause", 32'(csr_cause_o), 0);
        chk("reset.mret",  32'(csr_restore_mret_o), 0);
        rst_n = 1'b1;
        tick();

        // Illegal instruction: FLUSH next cycle, TRAP two cycles later
        instr_valid_i  = 1'b1;
        illegal_insn_i = 1'b1;
        tick();
        chk("ill.flush_state", 32'(debug_state_o), 32'(S_FLUSH));
        chk("ill.flush_halt",  32'(halt_id_o), 1);
        chk("ill.flush_save",  32'(csr_save_cause_o), 0);
        clear_instr();
        tick();
        chk_trap("ill", 6'h02, 1'b1, 5'h1F, 1'b0, 5'd0);
        tick();
        chk_idle("ill.after");

        // ebrk and ecall together: ebrk wins
        instr_valid_i = 1'b1;
        ebrk_insn_i   = 1'b1;
        ecall_insn_i  = 1'b1;
        tick();
        clear_instr();
        tick();
        chk_trap("ebrk", 6'h03, 1'b1, 5'h1F, 1'b0, 5'd0);
        tick();

        // Interrupt id 7 with no valid instruction: saves IF pc
        irq_i          = 1'b1;
        irq_id_i       = 5'd7;
        m_irq_enable_i = 1'b1;
        tick();
        chk("irq7.sample_state", 32'(debug_state_o), 32'(S_IDLE));
        irq_i = 1'b0;
        tick();
        chk("irq7.flush_state", 32'(debug_state_o), 32'(S_FLUSH));
        tick();
        chk_trap("irq7", 6'h27, 1'b0, 5'd7, 1'b1, 5'd7);
        tick();
        chk_idle("irq7.after");

        // ecall with lsu busy for 3 cycles: halt high for 4 cycles
        instr_valid_i = 1'b1;
        ecall_insn_i  = 1'b1;
        lsu_busy_i    = 1'b1;
        tick();
        chk("ecall.halt1", 32'(halt_id_o), 1);
        clear_instr();
        tick();
        chk("ecall.halt2", 32'(halt_id_o), 1);
        tick();
        chk("ecall.halt3",  32'(halt_id_o), 1);
        chk("ecall.nosave", 32'(csr_save_cause_o), 0);
        chk("ecall.still_flush", 32'(debug_state_o), 32'(S_FLUSH));
        lsu_busy_i = 1'b0;
        tick();
        chk_trap("ecall", 6'h0B, 1'b1, 5'h1F, 1'b0, 5'd0);
        tick();
        chk_idle("ecall.after");

        // Pending irq id 3 plus illegal in the same cycle: exception first
        irq_i    = 1'b1;
        irq_id_i = 5'd3;
        tick();
        instr_valid_i  = 1'b1;
        illegal_insn_i = 1'b1;
        tick();
        chk("prio.flush_state", 32'(debug_state_o), 32'(S_FLUSH));
        clear_instr();
        irq_i          = 1'b0;
        m_irq_enable_i = 1'b0;
        tick();
        chk_trap("prio.exc", 6'h02, 1'b1, 5'h1F, 1'b0, 5'd0);
        tick();
        chk_idle("prio.idle");
        // MIE re-enabled: the still-pending interrupt is taken
        m_irq_enable_i = 1'b1;
        tick();
        chk("prio.irq_flush", 32'(debug_state_o), 32'(S_FLUSH));
        // MIE drops mid-flush: trap is committed anyway
        m_irq_enable_i = 1'b0;
        tick();
        chk_trap("prio.irq", 6'h23, 1'b0, 5'd3, 1'b1, 5'd3);
        tick();
        chk_idle("prio.irq_after");

        // Interrupt with a valid instruction in ID saves the ID pc
        irq_i          = 1'b1;
        irq_id_i       = 5'd5;
        m_irq_enable_i = 1'b1;
        tick();
        irq_i         = 1'b0;
        instr_valid_i = 1'b1;
        tick();
        clear_instr();
        tick();
        chk_trap("irq5", 6'h25, 1'b1, 5'd5, 1'b1, 5'd5);
        tick();

        // mret
        instr_valid_i = 1'b1;
        mret_insn_i   = 1'b1;
        tick();
        chk("mret.state",   32'(debug_state_o), 32'(S_MRET));
        chk("mret.restore", 32'(csr_restore_mret_o), 1);
        chk("mret.pc_set",  32'(pc_set_o), 1);
        chk("mret.pc_mux",  32'(pc_mux_o), P_MRET);
        chk("mret.halt",    32'(halt_id_o), 1);
        chk("mret.nosave",  32'(csr_save_cause_o), 0);
        clear_instr();
        tick();
        chk_idle("mret.after");
        chk("mret.after_restore", 32'(csr_restore_mret_o), 0);

        // mret together with illegal: exception wins
        instr_valid_i  = 1'b1;
        illegal_insn_i = 1'b1;
        mret_insn_i    = 1'b1;
        tick();
        chk("mret_ill.state", 32'(debug_state_o), 32'(S_FLUSH));
        clear_instr();
        tick();
        chk_trap("mret_ill", 6'h02, 1'b1, 5'h1F, 1'b0, 5'd0);
        tick();

        // irq with MIE=0 is never acknowledged
        m_irq_enable_i = 1'b0;
        irq_i          = 1'b1;
        irq_id_i       = 5'd9;
        seen_ack       = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (irq_ack_o || debug_state_o != S_IDLE) seen_ack = 1'b1;
        end
        chk("mie0.no_ack", 32'(seen_ack), 0);
        irq_i = 1'b0;
        tick();

        // Reset during FLUSH abandons the trap
        instr_valid_i  = 1'b1;
        illegal_insn_i = 1'b1;
        tick();
        chk("rst.flush_state", 32'(debug_state_o), 32'(S_FLUSH));
        clear_instr();
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle("rst.async");
        tick();
        rst_n     = 1'b1;
        seen_save = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (csr_save_cause_o || irq_ack_o || debug_state_o != S_IDLE) seen_save = 1'b1;
        end
        chk("rst.no_save_after", 32'(seen_save), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
